seg_param_bank: RTL and testbench

SEG_PARAM_BANK -- requirements
Module: seg_param_bank

---
 rtl/seg_param_bank.sv | 183 ++++++++++++++++++
 tb/tb_seg_param_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_param_bank.sv
// Segmented parameter bank: one shadow set (cycle, freq_div, rep) per segment,
// committed to the active outputs on request, either immediately or at loop end.
module seg_param_bank #(
  parameter int NUM_SEGMENTS     = 2,
  parameter int CYCLE_WIDTH      = 16,
  parameter int FREQ_DIV_WIDTH   = 32,
  parameter int REP_WIDTH        = 32,
  parameter int DEFAULT_FREQ_DIV = 10,
  parameter int MIN_FREQ_DIV     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [$clog2(NUM_SEGMENTS)-1:0] wseg,
  input  logic [1:0]                      wfield,
  input  logic [31:0]                     wdata,
  input  logic                            req_valid,
  input  logic [3:0]                      req_seg,
  input  logic                            req_mode,
  output logic                            req_ready,
  input  logic                            loop_end,
  output logic [3:0]                      cur_seg,
  output logic [CYCLE_WIDTH-1:0]          cycle,
  output logic [FREQ_DIV_WIDTH-1:0]       freq_div,
  output logic [REP_WIDTH-1:0]            rep,
  output logic                            done,
  output logic                            switched,
  output logic                            err
);

  localparam int SEG_W = $clog2(NUM_SEGMENTS);
  localparam logic [4:0] NSEG = 5'(NUM_SEGMENTS);
  localparam logic [FREQ_DIV_WIDTH-1:0] DEF_FD = FREQ_DIV_WIDTH'(DEFAULT_FREQ_DIV);
  localparam logic [FREQ_DIV_WIDTH-1:0] MIN_FD = FREQ_DIV_WIDTH'(MIN_FREQ_DIV);
  localparam logic [REP_WIDTH-1:0] REP_INF = {REP_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic [CYCLE_WIDTH-1:0]    sh_cycle_r [NUM_SEGMENTS];
  logic [FREQ_DIV_WIDTH-1:0] sh_fd_r    [NUM_SEGMENTS];
  logic [REP_WIDTH-1:0]      sh_rep_r   [NUM_SEGMENTS];

  logic [3:0]                lat_seg_r;
  logic                      lat_mode_r;
  logic                      ready_r;
  logic [3:0]                cur_seg_r;
  logic [CYCLE_WIDTH-1:0]    cycle_r;
  logic [FREQ_DIV_WIDTH-1:0] fd_r;
  logic [REP_WIDTH-1:0]      rep_r;
  logic [REP_WIDTH-1:0]      cnt_r;
  logic                      done_r;
  logic                      switched_r;
  logic                      err_r;

  logic [SEG_W-1:0]          req_idx_s;
  logic [SEG_W-1:0]          app_idx_s;
  logic                      seg_ok_s;
  logic                      req_legal_s;
  logic                      reject_s;

  // Shadow bank: defaults on reset, field writes accepted in every FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        sh_cycle_r[i] <= {CYCLE_WIDTH{1'b0}};
        sh_fd_r[i]    <= DEF_FD;
        sh_rep_r[i]   <= REP_INF;
      end
    end else if (we) begin
      case (wfield)
        2'd0:    sh_cycle_r[wseg] <= wdata[CYCLE_WIDTH-1:0];
        2'd1:    sh_fd_r[wseg]    <= wdata[FREQ_DIV_WIDTH-1:0];
        2'd2:    sh_rep_r[wseg]   <= wdata[REP_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Request legality: segment in range and its shadow divider not below the minimum
  always_comb begin
    req_idx_s   = req_seg[SEG_W-1:0];
    app_idx_s   = lat_seg_r[SEG_W-1:0];
    seg_ok_s    = ({1'b0, req_seg} < NSEG);
    req_legal_s = 1'b0;
    if (seg_ok_s) begin
      req_legal_s = (sh_fd_r[req_idx_s] >= MIN_FD);
    end else begin
      req_legal_s = 1'b0;
    end
  end

  // Next-state logic; a rejected request leaves the FSM in IDLE
  always_comb begin
    next_state_s = state_r;
    reject_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_legal_s) begin
          next_state_s = req_mode ? ST_WAIT : ST_APPLY;
        end else if (req_valid) begin
          reject_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!lat_mode_r || loop_end || done_r) begin
          next_state_s = ST_APPLY;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_APPLY: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State register, ready flag and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      lat_seg_r  <= 4'd0;
      lat_mode_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == ST_IDLE);
      if (state_r == ST_IDLE && req_valid) begin
        lat_seg_r  <= req_seg;
        lat_mode_r <= req_mode;
      end
    end
  end

  // Active parameters, loop counter and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_seg_r  <= 4'd0;
      cycle_r    <= {CYCLE_WIDTH{1'b0}};
      fd_r       <= DEF_FD;
      rep_r      <= REP_INF;
      cnt_r      <= {REP_WIDTH{1'b0}};
      done_r     <= 1'b0;
      switched_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      switched_r <= 1'b0;
      err_r      <= reject_s;
      if (state_r == ST_APPLY) begin
        // A loop end landing here belongs to the outgoing segment and is dropped
        cur_seg_r  <= lat_seg_r;
        cycle_r    <= sh_cycle_r[app_idx_s];
        fd_r       <= sh_fd_r[app_idx_s];
        rep_r      <= sh_rep_r[app_idx_s];
        cnt_r      <= {REP_WIDTH{1'b0}};
        done_r     <= 1'b0;
        switched_r <= 1'b1;
      end else if (loop_end && rep_r != REP_INF && !done_r) begin
        // Count stops at rep+1 because done blocks further increments
        cnt_r <= cnt_r + {{(REP_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_r == rep_r) begin
          done_r <= 1'b1;
        end
      end
    end
  end

  assign req_ready = ready_r;
  assign cur_seg   = cur_seg_r;
  assign cycle     = cycle_r;
  assign freq_div  = fd_r;
  assign rep       = rep_r;
  assign done      = done_r;
  assign switched  = switched_r;
  assign err       = err_r;

endmodule

// File: tb/tb_seg_param_bank.sv
// Scoreboard bench for seg_param_bank: a 2-segment and a 4-segment instance;
// expected SWITCHED/ERR events are queued by stimulus and checked by a monitor.
module tb_seg_param_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we, req_valid, req_mode, loop_end;
  logic [0:0]  wseg;
  logic [1:0]  wfield;
  logic [31:0] wdata;
  logic [3:0]  req_seg;
  logic        req_ready, done, switched, err;
  logic [3:0]  cur_seg;
  logic [15:0] cycle;
  logic [31:0] freq_div, rep;

  logic        we4, req_valid4, req_mode4, loop_end4;
  logic [1:0]  wseg4;
  logic [1:0]  wfield4;
  logic [31:0] wdata4;
  logic [3:0]  req_seg4;
  logic        req_ready4, done4, switched4, err4;
  logic [3:0]  cur_seg4;
  logic [15:0] cycle4;
  logic [31:0] freq_div4, rep4;

  seg_param_bank dut (
    .clk(clk), .rst(rst), .we(we), .wseg(wseg), .wfield(wfield), .wdata(wdata),
    .req_valid(req_valid), .req_seg(req_seg), .req_mode(req_mode), .req_ready(req_ready),
    .loop_end(loop_end), .cur_seg(cur_seg), .cycle(cycle), .freq_div(freq_div),
    .rep(rep), .done(done), .switched(switched), .err(err)
  );

  seg_param_bank #(.NUM_SEGMENTS(4)) dut4 (
    .clk(clk), .rst(rst), .we(we4), .wseg(wseg4), .wfield(wfield4), .wdata(wdata4),
    .req_valid(req_valid4), .req_seg(req_seg4), .req_mode(req_mode4), .req_ready(req_ready4),
    .loop_end(loop_end4), .cur_seg(cur_seg4), .cycle(cycle4), .freq_div(freq_div4),
    .rep(rep4), .done(done4), .switched(switched4), .err(err4)
  );

  typedef struct {
    logic        is_err;
    logic [3:0]  seg;
    logic [15:0] cyc;
    logic [31:0] fd;
    logic [31:0] rep;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  exp_t e0, e4;
  int tests = 0;
  int fails = 0;

  localparam logic [31:0] INF = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic [3:0] s, input logic [15:0] c,
                              input logic [31:0] f, input logic [31:0] r);
    exp_t e;
    e.is_err = is_err; e.seg = s; e.cyc = c; e.fd = f; e.rep = r;
    return e;
  endfunction

  task automatic check_ev(input string tag, input exp_t e, input logic sw, input logic er,
                          input logic [3:0] s, input logic [15:0] c, input logic [31:0] f,
                          input logic [31:0] r);
    chk({tag, "_event_kind"}, {30'd0, sw, er}, {30'd0, ~e.is_err, e.is_err});
    chk({tag, "_cur_seg"}, 32'(s), 32'(e.seg));
    chk({tag, "_cycle"}, 32'(c), 32'(e.cyc));
    chk({tag, "_freq_div"}, f, e.fd);
    chk({tag, "_rep"}, r, e.rep);
  endtask

  // Monitor: every SWITCHED or ERR pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (switched || err)) begin
      if (q0.size() == 0) begin
        chk("dut2_unexpected_event", {30'd0, switched, err}, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check_ev("dut2", e0, switched, err, cur_seg, cycle, freq_div, rep);
      end
    end
    if (!rst && (switched4 || err4)) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_event", {30'd0, switched4, err4}, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check_ev("dut4", e4, switched4, err4, cur_seg4, cycle4, freq_div4, rep4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [0:0] s, input logic [1:0] f, input logic [31:0] d);
    we = 1'b1; wseg = s; wfield = f; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic req(input logic [3:0] s, input logic m);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_seg = s; req_mode = m;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse_loop();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cur_seg"}, 32'(cur_seg), 32'd0);
    chk({tag, "_cycle"}, 32'(cycle), 32'd0);
    chk({tag, "_freq_div"}, freq_div, 32'd10);
    chk({tag, "_rep"}, rep, INF);
    chk({tag, "_flags"}, {29'd0, done, switched, err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; wseg = 1'b0; wfield = 2'd0; wdata = 32'd0;
    req_valid = 1'b0; req_seg = 4'd0; req_mode = 1'b0; loop_end = 1'b0;
    we4 = 1'b0; wseg4 = 2'd0; wfield4 = 2'd0; wdata4 = 32'd0;
    req_valid4 = 1'b0; req_seg4 = 4'd0; req_mode4 = 1'b0; loop_end4 = 1'b0;
    wait_n(3);
    rst = 1'b0;
    chk_reset("reset");
    chk("reset_dut4_freq_div", freq_div4, 32'd10);

    // Immediate commit of seg1 with one-cycle SWITCHED latency
    wr(1'b1, 2'd0, 32'd4000);
    wr(1'b1, 2'd1, 32'd20);
    wr(1'b1, 2'd2, INF);
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd20, INF));
    req(4'd1, 1'b0);
    chk("apply_no_early_switch", {31'd0, switched}, 32'd0);
    tick();
    chk("switched_latency", {31'd0, switched}, 32'd1);
    wait_n(2);

    // Finite repeat count: rep=2 gives DONE on the third loop end, then holds
    wr(1'b1, 2'd2, 32'd2);
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd20, 32'd2));
    req(4'd1, 1'b0);
    wait_n(3);
    pulse_loop(); pulse_loop();
    chk("done_after_two_loops", {31'd0, done}, 32'd0);
    pulse_loop();
    chk("done_after_three_loops", {31'd0, done}, 32'd1);
    pulse_loop();
    chk("done_held", {31'd0, done}, 32'd1);

    // Re-request restarts counting; then a loop-end request waits for LOOP_END
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd20, 32'd2));
    req(4'd1, 1'b0);
    wait_n(3);
    chk("rerequest_clears_done", {31'd0, done}, 32'd0);
    q0.push_back(mk(1'b0, 4'd0, 16'd0, 32'd10, INF));
    req(4'd0, 1'b1);
    wait_n(3);
    chk("wait_no_switch", {31'd0, switched}, 32'd0);
    chk("wait_keeps_seg", 32'(cur_seg), 32'd1);
    chk("wait_not_ready", {31'd0, req_ready}, 32'd0);
    pulse_loop();
    tick();
    chk("loop_end_switch", {31'd0, switched}, 32'd1);
    chk("loop_end_seg", 32'(cur_seg), 32'd0);
    wait_n(2);

    // LOOP_END during APPLY is dropped; loop-end request with DONE high goes at once
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd20, 32'd2));
    req(4'd1, 1'b0);
    pulse_loop();
    pulse_loop(); pulse_loop();
    chk("apply_loop_end_dropped", {31'd0, done}, 32'd0);
    pulse_loop();
    chk("done_after_apply", {31'd0, done}, 32'd1);
    q0.push_back(mk(1'b0, 4'd0, 16'd0, 32'd10, INF));
    req(4'd0, 1'b1);
    wait_n(3);
    chk("done_path_seg", 32'(cur_seg), 32'd0);
    pulse_loop(); pulse_loop(); pulse_loop();
    chk("infinite_rep_no_done", {31'd0, done}, 32'd0);

    // Rejections: out-of-range segment and zero divider
    q0.push_back(mk(1'b1, 4'd0, 16'd0, 32'd10, INF));
    req(4'd5, 1'b0);
    chk("err_pulse_seg5", {31'd0, err}, 32'd1);
    chk("ready_after_err", {31'd0, req_ready}, 32'd1);
    tick();
    chk("err_one_cycle", {31'd0, err}, 32'd0);
    wr(1'b1, 2'd1, 32'd0);
    q0.push_back(mk(1'b1, 4'd0, 16'd0, 32'd10, INF));
    req(4'd1, 1'b0);
    wait_n(2);
    chk("err_fd0_seg_kept", 32'(cur_seg), 32'd0);

    // Shadow write in the APPLY cycle: active gets the old value, shadow the new one
    wr(1'b1, 2'd1, 32'd55);
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd55, 32'd2));
    req(4'd1, 1'b0);
    wr(1'b1, 2'd1, 32'd99);
    wait_n(2);
    chk("apply_write_old_fd", freq_div, 32'd55);
    q0.push_back(mk(1'b0, 4'd1, 16'd4000, 32'd99, 32'd2));
    req(4'd1, 1'b0);
    wait_n(3);

    // Reset while in WAIT abandons the request and restores shadow defaults
    req(4'd0, 1'b1);
    wait_n(2);
    chk("in_wait_before_reset", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    chk_reset("wait_reset");
    wait_n(3);
    chk("no_switch_after_reset", {31'd0, switched}, 32'd0);
    q0.push_back(mk(1'b0, 4'd1, 16'd0, 32'd10, INF));
    req(4'd1, 1'b0);
    wait_n(3);

    // Four-segment instance: load distinct sets, then commit each in turn
    for (int i = 0; i < 4; i++) begin
      we4 = 1'b1; wseg4 = 2'(i);
      wfield4 = 2'd0; wdata4 = 32'(100 + i); tick();
      wfield4 = 2'd1; wdata4 = 32'(20 + i);  tick();
      wfield4 = 2'd2; wdata4 = 32'(5 + i);   tick();
      we4 = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk("dut4_ready", {31'd0, req_ready4}, 32'd1);
      q4.push_back(mk(1'b0, 4'(i), 16'(100 + i), 32'(20 + i), 32'(5 + i)));
      req_valid4 = 1'b1; req_seg4 = 4'(i); req_mode4 = 1'b0;
      tick();
      req_valid4 = 1'b0;
      wait_n(3);
    end
    chk("dut4_final_seg", 32'(cur_seg4), 32'd3);

    wait_n(3);
    chk("dut2_queue_drained", 32'(q0.size()), 32'd0);
    chk("dut4_queue_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
